// File: rtl/k2_pkg.sv
// Shared definitions for the K2 inverse-scaling block.
// Holds the FSM state encoding, the default operand/exponent widths and
// the iteration-counter width helper used by k2inv_scale.
package k2_pkg;

  // Default operand/modulus width and shift-exponent width.
  localparam int K2_WIDTH = 32;
  localparam int K2_MW    = 6;

  // The counter must hold 2*m, so it needs one bit more than m.
  function automatic int k2_cnt_w(input int mw);
    return mw + 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NORM   = 2'd1,
    S_DOUBLE = 2'd2,
    S_DONE   = 2'd3
  } k2_state_e;

endpackage

// File: rtl/k2_moddbl.sv
// Combinational modular doubling: o_dbl = 2*i_x mod i_q, assuming i_x < i_q.
// Ports:
//   i_x   - operand, already reduced below i_q
//   i_q   - modulus
//   o_dbl - (2*i_x) reduced by a single conditional subtraction
module k2_moddbl
  import k2_pkg::*;
#(
  parameter int WIDTH = K2_WIDTH
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_dbl
);

  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;

  assign w_t   = {i_x, 1'b0};
  // When t >= Q, t - Q < Q fits in WIDTH bits, so the carry bit can be dropped.
  assign w_sub = w_t[WIDTH-1:0] - i_q;
  assign w_ge  = (w_t >= {1'b0, i_q});
  assign o_dbl = w_ge ? w_sub : w_t[WIDTH-1:0];

endmodule

// File: rtl/k2inv_scale.sv
// Computes C = X * 2^(2m) mod Q for Q = k*2^m + 1, which equals X * k^-2 mod Q
// and cancels the k^2 factor introduced by K2-RED reduction.
// One normalisation cycle, then 2m modular doublings, then a held result.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   in_valid/in_ready  - request handshake (ready only when idle)
//   X, Q, m            - operand, modulus, exponent (latched on acceptance)
//   out_valid/out_ready- result handshake
//   C                  - result, stable while out_valid is high
//   busy               - high whenever the block is not idle
module k2inv_scale
  import k2_pkg::*;
#(
  parameter int WIDTH = K2_WIDTH,
  parameter int MW    = K2_MW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Q,
  input  logic [MW-1:0]    m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             busy
);

  localparam int CW = k2_cnt_w(MW);

  k2_state_e        r_state;
  k2_state_e        w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_c;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;
  logic [WIDTH-1:0] w_norm;
  logic [WIDTH-1:0] w_dbl;

  // Bring X (< 2Q) into [0, Q) before doubling starts.
  assign w_norm = (r_x >= r_q) ? (r_x - r_q) : r_x;

  k2_moddbl #(.WIDTH(WIDTH)) u_moddbl (
    .i_x   (r_x),
    .i_q   (r_q),
    .o_dbl (w_dbl)
  );

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign C         = r_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_next = S_NORM;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_NORM: begin
        if (r_cnt != {CW{1'b0}}) begin
          w_next = S_DOUBLE;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DOUBLE: begin
        // Leave as the last iteration retires; a zero count also exits.
        if (r_cnt <= CW'(1)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DOUBLE;
        end
      end
      S_DONE: begin
        if (r_out_valid && out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, counter and registered handshake outputs.
  // out_valid is raised on the first DONE cycle edge, giving a 2m+2 latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x         <= {WIDTH{1'b0}};
      r_q         <= {WIDTH{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_c         <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_x   <= X;
            r_q   <= Q;
            r_cnt <= {m, 1'b0};
          end
        end
        S_NORM: begin
          r_x <= w_norm;
        end
        S_DOUBLE: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_x   <= w_dbl;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_c         <= r_x;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
      r_in_ready <= (w_next == S_IDLE);
      r_busy     <= (w_next != S_IDLE);
    end
  end

endmodule
